// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  // Requester indices, also used as the round-robin "last winner" encoding
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard of GPRs with an issued but not yet written-back result.
// A write-back in the current cycle hides the busy bit because the register
// file forwards that data. Entry 0 never reads busy.
module wb_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rd_busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Next busy vector: clear from write-back, then set from issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  function automatic logic query(input logic [AW-1:0] a);
    return (a != '0) && busy_q[a] && !(clr_en && (clr_addr == a));
  endfunction

  assign rs1_busy = query(rs1_addr);
  assign rs2_busy = query(rs2_addr);
  assign rd_busy  = query(rd_addr);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the GPR write port between ALU and LSU, with a
// registered write stage and an optional busy-bit scoreboard.
// Build option: define WBARB_SCOREBOARD_EN to include the scoreboard; when
// undefined the busy outputs are tied low and issue inputs are ignored.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [regfile_pkg::REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]                alu_data,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [regfile_pkg::REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]                mem_data,
  output logic [regfile_pkg::REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]                wb_data,
  output logic                           wb_we,
  input  logic                           issue_valid,
  input  logic [regfile_pkg::REG_AW-1:0] issue_rd,
  input  logic [regfile_pkg::REG_AW-1:0] rs1_addr,
  input  logic [regfile_pkg::REG_AW-1:0] rs2_addr,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
  output logic                           rd_busy
);
  import regfile_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic            last_q, last_d;      // winner of the most recent contention
  logic            grant_alu, grant_mem;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wb_we_q, wb_we_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  // Arbitration: a lone requester always wins; on contention the source that
  // did not win the previous contention goes first
  always_comb begin
    grant_alu = alu_valid & (~mem_valid | (last_q == REQ_MEM));
    grant_mem = mem_valid & (~alu_valid | (last_q == REQ_ALU));
    last_d    = last_q;
    if (alu_valid && mem_valid) last_d = grant_alu ? REQ_ALU : REQ_MEM;
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Write stage: capture the granted write; x0 is accepted but never written,
  // and address/data hold when nothing is written
  always_comb begin
    sel_rd    = grant_mem ? mem_rd   : alu_rd;
    sel_data  = grant_mem ? mem_data : alu_data;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if ((grant_alu || grant_mem) && (sel_rd != REG_ZERO)) begin
      wb_we_d   = 1'b1;
      wb_addr_d = sel_rd;
      wb_data_d = sel_data;
    end
  end

  // Pointer and write-stage registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= REQ_MEM;             // ALU wins the first contention
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      last_q    <= last_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

`ifdef WBARB_SCOREBOARD_EN
  wb_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .clr_en   (wb_we_q),
    .clr_addr (wb_addr_q),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (issue_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
  assign rd_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, a
// hand-written async-reset sequence, then randomized traffic against a model.
module tb_regfile_wb_arbiter;

`ifdef WBARB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 0, mem_valid = 0, issue_valid = 0;
  logic        alu_ready, mem_ready, wb_we, rs1_busy, rs2_busy, rd_busy;
  logic [4:0]  alu_rd = 0, mem_rd = 0, issue_rd = 0, rs1_addr = 0, rs2_addr = 0;
  logic [4:0]  wb_addr;
  logic [31:0] alu_data = 0, mem_data = 0, wb_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy)
  );

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
  } stim_t;

  typedef struct {
    stim_t s;
    logic ar, mr, we; logic [4:0] addr; logic [31:0] data; logic ck_ad;
    logic b1, b2, bd;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t S(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic iv, input logic [4:0] ird,
                              input logic [4:0] r1, input logic [4:0] r2);
    stim_t s;
    s.av = av; s.ard = ard; s.ad = ad; s.mv = mv; s.mrd = mrd; s.md = md;
    s.iv = iv; s.ird = ird; s.r1 = r1; s.r2 = r2;
    return s;
  endfunction

  function automatic vec_t V(input stim_t s, input logic ar, input logic mr, input logic we,
                             input logic [4:0] addr, input logic [31:0] data, input logic ck_ad,
                             input logic b1, input logic b2, input logic bd);
    vec_t v;
    v.s = s; v.ar = ar; v.mr = mr; v.we = we; v.addr = addr; v.data = data; v.ck_ad = ck_ad;
    v.b1 = b1; v.b2 = b2; v.bd = bd;
    return v;
  endfunction

  task automatic apply(input stim_t s);
    alu_valid = s.av; alu_rd = s.ard; alu_data = s.ad;
    mem_valid = s.mv; mem_rd = s.mrd; mem_data = s.md;
    issue_valid = s.iv; issue_rd = s.ird; rs1_addr = s.r1; rs2_addr = s.r2;
  endtask

  // Reference model state (random phase)
  bit          m_busy[32];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_alu_next;

  function automatic logic m_q(input logic [4:0] a);
    return (a != 0) && m_busy[a] && !(m_we && m_addr == a);
  endfunction

  vec_t  tbl[19];
  stim_t idle;

  initial begin
    idle = S(0,0,0, 0,0,0, 0,0, 0,0);
    //           inputs                                                 ar mr we addr data          ck b1 b2 bd
    tbl[0]  = V(idle,                                                  0, 0, 0, 0, 32'h0,        1, 0, 0, 0);
    tbl[1]  = V(S(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0),                  1, 0, 0, 0, 32'h0,        0, 0, 0, 0);
    tbl[2]  = V(idle,                                                  0, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0, 0);
    tbl[3]  = V(idle,                                                  0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0, 0);
    tbl[4]  = V(S(1,1,32'h11, 1,2,32'h22, 0,0, 0,0),                   1, 0, 0, 0, 32'h0,        0, 0, 0, 0);
    tbl[5]  = V(S(1,3,32'h33, 1,2,32'h22, 0,0, 0,0),                   0, 1, 1, 1, 32'h11,       1, 0, 0, 0);
    tbl[6]  = V(S(1,3,32'h33, 1,4,32'h44, 0,0, 0,0),                   1, 0, 1, 2, 32'h22,       1, 0, 0, 0);
    tbl[7]  = V(S(1,6,32'h66, 1,4,32'h44, 0,0, 0,0),                   0, 1, 1, 3, 32'h33,       1, 0, 0, 0);
    tbl[8]  = V(S(1,6,32'h66, 0,0,0, 0,0, 0,0),                        1, 0, 1, 4, 32'h44,       1, 0, 0, 0);
    tbl[9]  = V(S(0,0,0, 1,0,32'h77, 0,0, 0,0),                        0, 1, 1, 6, 32'h66,       1, 0, 0, 0);
    tbl[10] = V(idle,                                                  0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
    tbl[11] = V(S(0,0,0, 0,0,0, 1,7, 7,0),                             0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
    tbl[12] = V(S(1,7,32'h70, 0,0,0, 0,0, 7,0),                        1, 0, 0, 0, 32'h0,        0, 1, 0, 0);
    tbl[13] = V(S(0,0,0, 0,0,0, 0,0, 7,0),                             0, 0, 1, 7, 32'h70,       1, 0, 0, 0);
    tbl[14] = V(S(0,0,0, 0,0,0, 0,0, 7,0),                             0, 0, 0, 0, 32'h0,        0, 0, 0, 0);
    tbl[15] = V(S(1,9,32'h99, 0,0,0, 0,0, 0,0),                        1, 0, 0, 0, 32'h0,        0, 0, 0, 0);
    tbl[16] = V(S(0,0,0, 0,0,0, 1,9, 0,9),                             0, 0, 1, 9, 32'h99,       1, 0, 0, 0);
    tbl[17] = V(S(0,0,0, 0,0,0, 0,9, 0,9),                             0, 0, 0, 0, 32'h0,        0, 0, 1, 1);
    tbl[18] = V(S(0,0,0, 0,0,0, 0,0, 9,0),                             0, 0, 0, 0, 32'h0,        0, 1, 0, 0);

    // Reset state is visible without any clock edge
    apply(S(0,0,0, 0,0,0, 0,7, 7,7));
    #1 rst_n = 1'b0;
    #2;
    chk("rst_we", wb_we, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_busy", {rs1_busy, rs2_busy, rd_busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].s);
      @(negedge clk);
      chk($sformatf("t%0d_alu_ready", i), alu_ready, tbl[i].ar);
      chk($sformatf("t%0d_mem_ready", i), mem_ready, tbl[i].mr);
      chk($sformatf("t%0d_wb_we", i), wb_we, tbl[i].we);
      if (tbl[i].ck_ad) begin
        chk($sformatf("t%0d_wb_addr", i), wb_addr, tbl[i].addr);
        chk($sformatf("t%0d_wb_data", i), wb_data, tbl[i].data);
      end
      chk($sformatf("t%0d_rs1_busy", i), rs1_busy, SB_EN & tbl[i].b1);
      chk($sformatf("t%0d_rs2_busy", i), rs2_busy, SB_EN & tbl[i].b2);
      chk($sformatf("t%0d_rd_busy", i), rd_busy, SB_EN & tbl[i].bd);
      @(posedge clk); #1;
    end

    // Async reset with a write in flight; pointer left favouring MEM beforehand
    apply(S(1,12,32'hC0FFEE, 1,13,32'hD00D, 0,0, 9,0));
    @(negedge clk);
    chk("pre_alu_ready", alu_ready, 1);
    chk("pre_mem_ready", mem_ready, 0);
    @(posedge clk); #1;
    chk("pre_wb_we", wb_we, 1);
    chk("pre_wb_addr", wb_addr, 12);
    chk("pre_rs1_busy", rs1_busy, SB_EN);
    apply(S(1,14,32'hA1, 1,13,32'hD00D, 0,0, 9,0));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", wb_we, 0);
    chk("mid_rst_addr", wb_addr, 0);
    chk("mid_rst_data", wb_data, 0);
    chk("mid_rst_rs1_busy", rs1_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_mem_ready", mem_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_wb_we", wb_we, 1);
    chk("post_rst_wb_addr", wb_addr, 14);
    chk("post_rst_wb_data", wb_data, 32'hA1);
    apply(idle);

    // Randomized traffic against the reference model
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    foreach (m_busy[k]) m_busy[k] = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_alu_next = 1;
    begin
      bit pa = 0, pm = 0;
      logic [4:0] pa_rd = 0, pm_rd = 0, ird, r1, r2, wrd;
      logic [31:0] pa_d = 0, pm_d = 0;
      logic iv, ga, gm;
      for (int c = 0; c < 400; c++) begin
        if (!pa && $urandom_range(0, 99) < 60) begin
          pa = 1; pa_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); pa_d = $urandom;
        end
        if (!pm && $urandom_range(0, 99) < 60) begin
          pm = 1; pm_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); pm_d = $urandom;
        end
        ird = 5'($urandom_range(0, 31));
        r1  = 5'($urandom_range(0, 31));
        r2  = 5'($urandom_range(0, 31));
        iv  = ($urandom_range(0, 2) == 0) && !m_q(ird);
        apply(S(pa, pa_rd, pa_d, pm, pm_rd, pm_d, iv, ird, r1, r2));
        ga = pa && (!pm || m_alu_next);
        gm = pm && (!pa || !m_alu_next);
        @(negedge clk);
        chk("rnd_alu_ready", alu_ready, ga);
        chk("rnd_mem_ready", mem_ready, gm);
        chk("rnd_wb_we", wb_we, m_we);
        if (m_we) begin
          chk("rnd_wb_addr", wb_addr, m_addr);
          chk("rnd_wb_data", wb_data, m_data);
        end
        chk("rnd_rs1_busy", rs1_busy, SB_EN & m_q(r1));
        chk("rnd_rs2_busy", rs2_busy, SB_EN & m_q(r2));
        chk("rnd_rd_busy", rd_busy, SB_EN & m_q(ird));
        // advance the model across the clock edge
        if (m_we) m_busy[m_addr] = 0;
        if (iv && ird != 0) m_busy[ird] = 1;
        if (pa && pm) m_alu_next = gm;
        m_we = 0;
        if (ga || gm) begin
          wrd = ga ? pa_rd : pm_rd;
          if (wrd != 0) begin
            m_we = 1; m_addr = wrd; m_data = ga ? pa_d : pm_d;
          end
        end
        if (ga) pa = 0;
        if (gm) pm = 0;
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
